// File: rtl/cbus_axi_bridge_if.sv
// AXI3 32-bit bus bundle between the CPU bridge and the interconnect.
// Master drives address/write channels, slave drives read/response channels.
interface cbus_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cbus_axi_bridge.sv
// CPU bus to AXI3 master bridge, one outstanding INCR burst at a time.
// Write beats stream from the requester, advanced by each cresp_ready.
module cbus_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        creq_valid,
  input  logic        creq_is_write,
  input  logic [31:0] creq_addr,
  input  logic [2:0]  creq_size,
  input  logic [3:0]  creq_len,
  input  logic [3:0]  creq_strobe,
  input  logic [31:0] creq_data,
  output logic        cresp_ready,
  output logic        cresp_last,
  output logic [31:0] cresp_data,
  cbus_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE, AR, R, AW, W, B
  } state_t;

  state_t      state, state_d;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [3:0]  len_q;
  logic [3:0]  beat_q;
  logic        accept;
  logic        w_hs;
  logic        w_final;
  logic        in_ar, in_aw, in_w;

  assign accept  = (state == IDLE) && creq_valid;
  assign w_hs    = (state == W) && axi.wready;
  assign w_final = (beat_q == len_q);
  assign in_ar   = (state == AR);
  assign in_aw   = (state == AW);
  assign in_w    = (state == W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      size_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        addr_q <= creq_addr;
        size_q <= creq_size;
        len_q  <= creq_len;
        beat_q <= '0;
      end else if (w_hs) begin
        beat_q <= beat_q + 4'd1;
      end
    end
  end

  // The final write beat is acknowledged by B, not by its W handshake.
  always_comb begin
    state_d     = state;
    cresp_ready = 1'b0;
    cresp_last  = 1'b0;
    cresp_data  = '0;
    unique case (state)
      IDLE: begin
        if (creq_valid) state_d = creq_is_write ? AW : AR;
      end
      AR: begin
        if (axi.arready) state_d = R;
      end
      R: begin
        if (axi.rvalid) begin
          cresp_ready = 1'b1;
          cresp_last  = axi.rlast;
          cresp_data  = axi.rdata;
          if (axi.rlast) state_d = IDLE;
        end
      end
      AW: begin
        if (axi.awready) state_d = W;
      end
      W: begin
        if (axi.wready) begin
          if (w_final) state_d = B;
          else cresp_ready = 1'b1;
        end
      end
      B: begin
        if (axi.bvalid) begin
          cresp_ready = 1'b1;
          cresp_last  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign axi.arvalid = in_ar;
  assign axi.awvalid = in_aw;
  assign axi.wvalid  = in_w;
  assign axi.rready  = (state == R);
  assign axi.bready  = (state == B);

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = in_ar ? addr_q : '0;
  assign axi.arlen   = in_ar ? len_q : '0;
  assign axi.arsize  = in_ar ? size_q : '0;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = in_aw ? addr_q : '0;
  assign axi.awlen   = in_aw ? len_q : '0;
  assign axi.awsize  = in_aw ? size_q : '0;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;

  assign axi.wid   = AXI_ID;
  assign axi.wdata = in_w ? creq_data : '0;
  assign axi.wstrb = in_w ? creq_strobe : '0;
  assign axi.wlast = in_w && w_final;

  // Response status and IDs are not reported back to the CPU.
  logic unused_axi;
  assign unused_axi = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Bench for cbus_axi_bridge: random-delay AXI slave plus a
// transaction-level model of the expected CPU-side responses.
module tb_cbus_axi_bridge;
  localparam logic [3:0] ID = 4'b0101;

  logic        clk = 1'b0;
  logic        reset;
  logic        creq_valid;
  logic        creq_is_write;
  logic [31:0] creq_addr;
  logic [2:0]  creq_size;
  logic [3:0]  creq_len;
  logic [3:0]  creq_strobe;
  logic [31:0] creq_data;
  logic        cresp_ready;
  logic        cresp_last;
  logic [31:0] cresp_data;

  cbus_axi_bridge_if axi();

  cbus_axi_bridge #(.AXI_ID(ID)) dut (
    .clk(clk),
    .reset(reset),
    .creq_valid(creq_valid),
    .creq_is_write(creq_is_write),
    .creq_addr(creq_addr),
    .creq_size(creq_size),
    .creq_len(creq_len),
    .creq_strobe(creq_strobe),
    .creq_data(creq_data),
    .cresp_ready(cresp_ready),
    .cresp_last(cresp_last),
    .cresp_data(cresp_data),
    .axi(axi)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] rd_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [31:0] obs_data[$];
  logic        obs_last[$];
  logic [31:0] obs_wdata[$];
  logic [3:0]  obs_wstrb[$];
  logic        obs_wlast[$];
  logic [53:0] obs_a;
  int viol, first_pulse, first_valid, timed_out;

  function automatic logic [53:0] exp_a(input logic [31:0] addr,
                                        input logic [2:0] size,
                                        input logic [3:0] len);
    return {ID, addr, len, size, 2'b01, 2'b00, 4'h0, 3'h0};
  endfunction

  task automatic slave_quiet();
    axi.arready = 0; axi.awready = 0; axi.wready = 0;
    axi.rvalid = 0; axi.rdata = '0; axi.rlast = 0;
    axi.rid = '0; axi.rresp = '0;
    axi.bvalid = 0; axi.bid = '0; axi.bresp = '0;
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [3:0] len,
                         input int a_dly, input int d_dly,
                         input int b_dly, input int stop_after);
    int cyc, pulses, a_cnt, d_cnt, b_cnt, rb;
    bit a_done, w_done, b_done, done, have_a;
    bit a_hs, r_hs, w_hs, b_hs, exp_p;
    logic [53:0] snap, prev;
    cyc = 0; pulses = 0; a_cnt = 0; d_cnt = 0; b_cnt = 0; rb = 0;
    a_done = 0; w_done = 0; b_done = 0; done = 0; have_a = 0;
    prev = '0;
    obs_data.delete(); obs_last.delete();
    obs_wdata.delete(); obs_wstrb.delete(); obs_wlast.delete();
    obs_a = '0; viol = 0; first_pulse = -1; first_valid = -1;
    timed_out = 0;
    creq_valid = 1; creq_is_write = wr; creq_addr = addr;
    creq_size = size; creq_len = len;
    while (!done) begin
      creq_data = (pulses < wd_q.size()) ? wd_q[pulses] : 32'h0;
      creq_strobe = (pulses < ws_q.size()) ? ws_q[pulses] : 4'h0;
      axi.arready = !wr && !a_done && a_cnt >= a_dly;
      axi.awready = wr && !a_done && a_cnt >= a_dly;
      axi.rvalid = !wr && a_done && rb <= int'(len) && d_cnt >= d_dly;
      axi.rdata = (rb < rd_q.size()) ? rd_q[rb] : $urandom;
      axi.rlast = axi.rvalid && rb == int'(len);
      axi.rid = 4'($urandom); axi.rresp = 2'($urandom);
      axi.wready = wr && a_done && !w_done && d_cnt >= d_dly;
      axi.bvalid = wr && w_done && !b_done && b_cnt >= b_dly;
      axi.bid = 4'($urandom); axi.bresp = 2'($urandom);
      @(negedge clk);
      a_hs = (axi.arvalid && axi.arready) || (axi.awvalid && axi.awready);
      r_hs = axi.rvalid && axi.rready;
      w_hs = axi.wvalid && axi.wready;
      b_hs = axi.bvalid && axi.bready;
      if (wr ? (axi.arvalid || axi.rready)
             : (axi.awvalid || axi.wvalid || axi.bready)) viol++;
      if (axi.wvalid && (!a_done || w_done || axi.wid !== ID)) viol++;
      if (axi.arvalid || axi.awvalid) begin
        snap = wr ? {axi.awid, axi.awaddr, axi.awlen, axi.awsize,
                     axi.awburst, axi.awlock, axi.awcache, axi.awprot}
                  : {axi.arid, axi.araddr, axi.arlen, axi.arsize,
                     axi.arburst, axi.arlock, axi.arcache, axi.arprot};
        if (a_done || (have_a && snap !== prev)) viol++;
        if (first_valid < 0) first_valid = cyc;
        prev = snap; have_a = 1;
        if (a_hs) obs_a = snap; else a_cnt++;
      end
      if (w_hs) begin
        obs_wdata.push_back(axi.wdata);
        obs_wstrb.push_back(axi.wstrb);
        obs_wlast.push_back(axi.wlast);
        d_cnt = 0;
      end else if (axi.wvalid) d_cnt++;
      if (r_hs) begin rb++; d_cnt = 0; end
      else if (!wr && a_done && !axi.rvalid) d_cnt++;
      if (b_hs) b_done = 1; else if (w_done) b_cnt++;
      exp_p = r_hs || (w_hs && !axi.wlast) || b_hs;
      if (cresp_ready !== exp_p) viol++;
      if (cresp_ready) begin
        obs_data.push_back(cresp_data);
        obs_last.push_back(cresp_last);
        if (first_pulse < 0) first_pulse = cyc;
        pulses++;
      end
      if (w_hs && axi.wlast) w_done = 1;
      if (a_hs) a_done = 1;
      done = (cresp_ready && cresp_last) || b_done
          || (!wr && rb > int'(len))
          || (stop_after >= 0 && pulses >= stop_after);
      cyc++;
      if (cyc >= 300) begin timed_out = 1; done = 1; end
      @(posedge clk); #1;
    end
    slave_quiet();
  endtask

  task automatic test_reset();
    slave_quiet();
    creq_is_write = 1; creq_addr = $urandom; creq_size = 3'd2;
    creq_len = 4'd5; creq_strobe = 4'hF; creq_data = $urandom;
    reset = 1; creq_valid = 1;
    repeat (3) @(posedge clk);
    #1; reset = 0; creq_valid = 0;
    @(negedge clk);
    nvec++;
    if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
         cresp_ready, cresp_last} !== 7'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: got %b want 0", {axi.arvalid, axi.awvalid,
               axi.wvalid, axi.rready, axi.bready, cresp_ready, cresp_last});
    end
    nvec++;
    if ({axi.araddr, axi.awaddr, axi.wdata, cresp_data} !== 128'b0) begin
      nerr++;
      $display("FAIL reset_data: araddr %h awaddr %h wdata %h cdata %h want 0",
               axi.araddr, axi.awaddr, axi.wdata, cresp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    rd_q = '{32'h3C08BFAF}; wd_q.delete(); ws_q.delete();
    run_txn(0, 32'hBFC00000, 3'd2, 4'd0, 0, 0, 0, -1);
    creq_valid = 0;
    nvec++;
    if (viol !== 0 || timed_out !== 0) begin
      nerr++; $display("FAIL sread_proto: viol %0d tmo %0d want 0 0",
                       viol, timed_out);
    end
    nvec++;
    if (obs_a !== exp_a(32'hBFC00000, 3'd2, 4'd0)) begin
      nerr++; $display("FAIL sread_ar: got %h want %h", obs_a,
                       exp_a(32'hBFC00000, 3'd2, 4'd0));
    end
    nvec++;
    if (obs_data.size() !== 1 || obs_data[0] !== 32'h3C08BFAF
        || obs_last[0] !== 1'b1) begin
      nerr++; $display("FAIL sread_resp: n %0d data %h want 1 3c08bfaf",
                       obs_data.size(), obs_data[0]);
    end
    nvec++;
    if (first_valid !== 1 || first_pulse !== 2) begin
      nerr++; $display("FAIL sread_latency: ar %0d pulse %0d want 1 2",
                       first_valid, first_pulse);
    end
    @(negedge clk);
    nvec++;
    if ({axi.arvalid, axi.rready, cresp_ready} !== 3'b0
        || axi.araddr !== 32'h0) begin
      nerr++; $display("FAIL sread_idle: ctl %b araddr %h want 0",
                       {axi.arvalid, axi.rready, cresp_ready}, axi.araddr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_burst_read();
    rd_q.delete();
    for (int i = 0; i < 4; i++) rd_q.push_back($urandom);
    run_txn(0, 32'h1000_0040, 3'd2, 4'd3, $urandom_range(2, 0), 2, 0, -1);
    creq_valid = 0;
    nvec++;
    if (viol !== 0 || timed_out !== 0) begin
      nerr++; $display("FAIL bread_proto: viol %0d tmo %0d want 0 0",
                       viol, timed_out);
    end
    nvec++;
    if (obs_a !== exp_a(32'h1000_0040, 3'd2, 4'd3)) begin
      nerr++; $display("FAIL bread_ar: got %h want %h", obs_a,
                       exp_a(32'h1000_0040, 3'd2, 4'd3));
    end
    nvec++;
    if (obs_data.size() !== 4) begin
      nerr++; $display("FAIL bread_count: got %0d want 4", obs_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (obs_data[i] !== rd_q[i] || obs_last[i] !== (i == 3)) begin
        nerr++; $display("FAIL bread_beat%0d: got %h/%b want %h/%b", i,
                         obs_data[i], obs_last[i], rd_q[i], i == 3);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    rd_q.delete();
    wd_q = '{32'hDEADBEEF}; ws_q = '{4'b0011};
    run_txn(1, 32'h80000010, 3'd2, 4'd0, 0, 3, 1, -1);
    creq_valid = 0;
    nvec++;
    if (viol !== 0 || timed_out !== 0) begin
      nerr++; $display("FAIL swrite_proto: viol %0d tmo %0d want 0 0",
                       viol, timed_out);
    end
    nvec++;
    if (obs_a !== exp_a(32'h80000010, 3'd2, 4'd0)) begin
      nerr++; $display("FAIL swrite_aw: got %h want %h", obs_a,
                       exp_a(32'h80000010, 3'd2, 4'd0));
    end
    nvec++;
    if (obs_wdata.size() !== 1 || obs_wdata[0] !== 32'hDEADBEEF
        || obs_wstrb[0] !== 4'b0011 || obs_wlast[0] !== 1'b1) begin
      nerr++; $display("FAIL swrite_w: n %0d %h %b %b want 1 deadbeef 0011 1",
                       obs_wdata.size(), obs_wdata[0], obs_wstrb[0],
                       obs_wlast[0]);
    end
    nvec++;
    if (obs_last.size() !== 1 || obs_last[0] !== 1'b1) begin
      nerr++; $display("FAIL swrite_resp: n %0d last %b want 1 1",
                       obs_last.size(), obs_last[0]);
    end
    @(negedge clk);
    nvec++;
    if ({axi.awvalid, axi.wvalid, axi.bready, cresp_ready} !== 4'b0
        || axi.awaddr !== 32'h0 || axi.wdata !== 32'h0) begin
      nerr++; $display("FAIL swrite_idle: awaddr %h wdata %h want 0",
                       axi.awaddr, axi.wdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_burst_write();
    rd_q.delete(); wd_q.delete(); ws_q.delete();
    for (int i = 0; i < 4; i++) begin
      wd_q.push_back($urandom);
      ws_q.push_back(4'($urandom));
    end
    run_txn(1, 32'h2000_0100, 3'd2, 4'd3, 1, $urandom_range(1, 0), 2, -1);
    creq_valid = 0;
    nvec++;
    if (viol !== 0 || timed_out !== 0) begin
      nerr++; $display("FAIL bwrite_proto: viol %0d tmo %0d want 0 0",
                       viol, timed_out);
    end
    nvec++;
    if (obs_a !== exp_a(32'h2000_0100, 3'd2, 4'd3)) begin
      nerr++; $display("FAIL bwrite_aw: got %h want %h", obs_a,
                       exp_a(32'h2000_0100, 3'd2, 4'd3));
    end
    nvec++;
    if (obs_wdata.size() !== 4 || obs_last.size() !== 4) begin
      nerr++; $display("FAIL bwrite_count: w %0d pulses %0d want 4 4",
                       obs_wdata.size(), obs_last.size());
    end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (obs_wdata[i] !== wd_q[i] || obs_wstrb[i] !== ws_q[i]
          || obs_wlast[i] !== (i == 3) || obs_last[i] !== (i == 3)) begin
        nerr++; $display("FAIL bwrite_beat%0d: got %h %b %b %b want %h %b %b",
                         i, obs_wdata[i], obs_wstrb[i], obs_wlast[i],
                         obs_last[i], wd_q[i], ws_q[i], i == 3);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    rd_q.delete(); wd_q.delete(); ws_q.delete();
    for (int i = 0; i < 4; i++) rd_q.push_back($urandom);
    run_txn(0, 32'h3000_0000, 3'd2, 4'd3, 0, 1, 0, 1);
    nvec++;
    if (obs_data.size() !== 1 || obs_data[0] !== rd_q[0]) begin
      nerr++; $display("FAIL rst_mid_beat: n %0d %h want 1 %h",
                       obs_data.size(), obs_data[0], rd_q[0]);
    end
    reset = 1;
    axi.rvalid = 1; axi.rdata = $urandom; axi.rlast = 0;
    @(posedge clk); #1;
    reset = 0; creq_valid = 0;
    @(negedge clk);
    nvec++;
    if ({axi.rready, cresp_ready, cresp_last, axi.arvalid,
         axi.awvalid} !== 5'b0) begin
      nerr++; $display("FAIL rst_mid_out: got %b want 0", {axi.rready,
               cresp_ready, cresp_last, axi.arvalid, axi.awvalid});
    end
    @(posedge clk); #1;
    slave_quiet();
    rd_q.delete();
    for (int i = 0; i < 2; i++) rd_q.push_back($urandom);
    run_txn(0, 32'h3000_0800, 3'd2, 4'd1, 0, 0, 0, -1);
    creq_valid = 0;
    nvec++;
    if (viol !== 0 || timed_out !== 0 || first_pulse !== 2
        || obs_a !== exp_a(32'h3000_0800, 3'd2, 4'd1)) begin
      nerr++; $display("FAIL rst_mid_next: viol %0d tmo %0d pulse %0d ar %h",
                       viol, timed_out, first_pulse, obs_a);
    end
    nvec++;
    if (obs_data.size() !== 2 || obs_data[0] !== rd_q[0]
        || obs_data[1] !== rd_q[1] || obs_last[1] !== 1'b1) begin
      nerr++; $display("FAIL rst_mid_data: n %0d %h %h want 2 %h %h",
                       obs_data.size(), obs_data[0], obs_data[1],
                       rd_q[0], rd_q[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] len;
    len = 4'($urandom_range(3, 1));
    rd_q.delete(); wd_q.delete(); ws_q.delete();
    for (int i = 0; i <= int'(len); i++) rd_q.push_back($urandom);
    run_txn(0, 32'h4000_0000, 3'd2, len, 1, 1, 0, -1);
    nvec++;
    if (viol !== 0 || timed_out !== 0 || obs_data.size() !== int'(len) + 1
        || obs_data[len] !== rd_q[len] || obs_last[len] !== 1'b1) begin
      nerr++; $display("FAIL b2b_read: viol %0d n %0d want 0 %0d",
                       viol, obs_data.size(), int'(len) + 1);
    end
    rd_q.delete();
    wd_q = '{32'hCAFE_0001, 32'hCAFE_0002};
    ws_q = '{4'hF, 4'hC};
    run_txn(1, 32'h4000_1000, 3'd2, 4'd1, 0, 0, 0, -1);
    creq_valid = 0;
    nvec++;
    if (viol !== 0 || timed_out !== 0 || first_valid !== 1) begin
      nerr++; $display("FAIL b2b_write_start: viol %0d tmo %0d aw %0d want 0 0 1",
                       viol, timed_out, first_valid);
    end
    nvec++;
    if (obs_wdata.size() !== 2 || obs_wdata[1] !== 32'hCAFE_0002
        || obs_wstrb[1] !== 4'hC || obs_last.size() !== 2
        || obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1) begin
      nerr++; $display("FAIL b2b_write_beats: n %0d %h pulses %0d",
                       obs_wdata.size(), obs_wdata[1], obs_last.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit          wr;
    logic [3:0]  len;
    logic [31:0] addr;
    int          ad, dd;
    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom);
      len = 4'($urandom_range(7, 0));
      addr = $urandom & 32'hFFFF_FFFC;
      ad = $urandom_range(2, 0);
      dd = $urandom_range(2, 0);
      rd_q.delete(); wd_q.delete(); ws_q.delete();
      for (int i = 0; i <= int'(len); i++) begin
        rd_q.push_back($urandom);
        wd_q.push_back($urandom);
        ws_q.push_back(4'($urandom));
      end
      if (!wr) wd_q.delete();
      run_txn(wr, addr, 3'd2, len, ad, dd, $urandom_range(2, 0), -1);
      nvec++;
      if (viol !== 0 || timed_out !== 0 || first_valid !== 1
          || obs_a !== exp_a(addr, 3'd2, len)) begin
        nerr++; $display("FAIL rand%0d_proto: viol %0d tmo %0d av %0d a %h",
                         t, viol, timed_out, first_valid, obs_a);
      end
      nvec++;
      if (obs_last.size() !== int'(len) + 1) begin
        nerr++; $display("FAIL rand%0d_count: got %0d want %0d", t,
                         obs_last.size(), int'(len) + 1);
      end
      if (!wr) begin
        nvec++;
        if (first_pulse !== 2 + ad + dd) begin
          nerr++; $display("FAIL rand%0d_latency: got %0d want %0d", t,
                           first_pulse, 2 + ad + dd);
        end
      end
      for (int i = 0; i <= int'(len); i++) begin
        nvec++;
        if (obs_last[i] !== (i == int'(len))
            || (!wr && obs_data[i] !== rd_q[i])
            || (wr && (obs_wdata[i] !== wd_q[i] || obs_wstrb[i] !== ws_q[i]
                       || obs_wlast[i] !== (i == int'(len))))) begin
          nerr++; $display("FAIL rand%0d_beat%0d: wr %0d last %b rd %h wd %h",
                           t, i, wr, obs_last[i], obs_data[i], obs_wdata[i]);
        end
      end
      if (1'($urandom)) begin
        creq_valid = 0;
        repeat ($urandom_range(2, 1)) @(posedge clk);
        #1;
      end
    end
    creq_valid = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_read();
    test_single_write();
    test_burst_write();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule
